// File: rtl/o_buft_ser_pkg.sv
// Shared types and default parameters for the O_BUFT_DS serial driver.
// The state encoding and the guard-counter width are used by the top-level FSM.
package o_buft_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_LSB_FIRST    = 0;
    localparam int DEF_GUARD_CYCLES = 1;

    // Wide enough for the largest legal guard period (15).
    localparam int GCNT_W = 4;

endpackage

// File: rtl/o_buft_ser_hold.sv
// One-entry holding register in front of the shifter, with a registered ready.
// Ready is held low through reset and rises on the first edge after reset is released.
module o_buft_ser_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    input  logic             i_slot,
    output logic             o_ready,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic             r_ready;
    logic [WIDTH-1:0] r_data;

    logic w_xfer;
    logic w_capture;
    logic w_full_nxt;

    // A transfer during a load slot with the register empty bypasses straight
    // into the shifter, so only transfers outside a slot are captured here.
    assign w_xfer     = i_valid & r_ready;
    assign w_capture  = w_xfer & ~i_slot;
    assign w_full_nxt = r_full ? ~i_slot : w_capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            r_full  <= w_full_nxt;
            r_ready <= ~w_full_nxt;
        end
    end

    // NOTE: the data word is deliberately not reset; r_full qualifies it.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_data <= i_data;
        end
    end

    assign o_ready = r_ready;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/o_buft_ser_driver.sv
// Serializes parallel words onto the I/T pins of an O_BUFT_DS pad pair.
// Bursts run back-to-back without a gap; after a burst the pads tristate for GUARD_CYCLES.
module o_buft_ser_driver
    import o_buft_ser_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int LSB_FIRST    = DEF_LSB_FIRST,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_i,
    output logic             ser_t,
    output logic             busy,
    output logic             word_done
);

    localparam int                CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(WIDTH - 1);
    localparam logic [GCNT_W-1:0] GUARD_LAST = GCNT_W'(GUARD_CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [GCNT_W-1:0]  r_gcnt;
    logic [WIDTH-1:0]   r_sh;
    logic               r_ser_i;
    logic               r_ser_t;
    logic               r_busy;
    logic               r_word_done;

    logic               w_hold_ready;
    logic               w_hold_full;
    logic [WIDTH-1:0]   w_hold_data;
    logic               w_xfer;
    logic               w_last;
    logic               w_slot;
    logic               w_load;
    logic [WIDTH-1:0]   w_word;
    logic               w_first_bit;
    logic               w_next_bit;
    logic [CNT_W-1:0]   w_cnt_nxt;

    o_buft_ser_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_data  (data_in),
        .i_valid (data_valid),
        .i_slot  (w_slot),
        .o_ready (w_hold_ready),
        .o_full  (w_hold_full),
        .o_data  (w_hold_data)
    );

    // A new word may start from IDLE or on the last bit of the current word.
    assign w_last      = (r_cnt == LAST_BIT);
    assign w_slot      = (r_state == ST_IDLE) || ((r_state == ST_SHIFT) && w_last);
    assign w_xfer      = data_valid & w_hold_ready;
    assign w_load      = w_slot & (w_hold_full | w_xfer);
    assign w_word      = w_hold_full ? w_hold_data : data_in;
    assign w_first_bit = (LSB_FIRST != 0) ? w_word[0] : w_word[WIDTH-1];
    assign w_next_bit  = (LSB_FIRST != 0) ? r_sh[1]   : r_sh[WIDTH-2];
    assign w_cnt_nxt   = r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_sh <= w_word;
        end else if ((r_state == ST_SHIFT) && !w_last) begin
            r_sh <= (LSB_FIRST != 0) ? (r_sh >> 1) : (r_sh << 1);
        end
    end

    // ser_i and ser_t are both registered here so they always change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_gcnt      <= '0;
            r_ser_i     <= 1'b0;
            r_ser_t     <= 1'b0;
            r_busy      <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            if (w_load) begin
                r_state <= ST_SHIFT;
                r_cnt   <= '0;
                r_ser_i <= w_first_bit;
                r_ser_t <= 1'b1;
                r_busy  <= 1'b1;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                    end
                    ST_SHIFT: begin
                        if (!w_last) begin
                            r_cnt       <= w_cnt_nxt;
                            r_ser_i     <= w_next_bit;
                            r_word_done <= (w_cnt_nxt == LAST_BIT);
                        end else begin
                            r_state <= ST_GUARD;
                            r_ser_i <= 1'b0;
                            r_ser_t <= 1'b0;
                            r_gcnt  <= '0;
                        end
                    end
                    ST_GUARD: begin
                        if (r_gcnt == GUARD_LAST) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_gcnt  <= '0;
                        end else begin
                            r_gcnt <= r_gcnt + GCNT_W'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign data_ready = w_hold_ready;
    assign ser_i      = r_ser_i;
    assign ser_t      = r_ser_t;
    assign busy       = r_busy;
    assign word_done  = r_word_done;

endmodule

// File: tb/tb_o_buft_ser_driver.sv
// Bench for o_buft_ser_driver: dut_a uses defaults (MSB first, 1 guard cycle),
// dut_b is LSB first with 3 guard cycles. Accepted words feed a per-DUT bit scoreboard.
module tb_o_buft_ser_driver;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] valid;
    logic [7:0] din [2];

    logic a_ready, a_ser_i, a_ser_t, a_busy, a_done;
    logic b_ready, b_ser_i, b_ser_t, b_busy, b_done;

    int n_checks = 0;
    int n_err    = 0;
    int wd_cnt [2];
    int run_a      = 0;
    int last_run_a = 0;
    logic last_waited;

    // Each entry: {last_bit_of_word, expected_ser_i}
    logic [1:0] q0 [$];
    logic [1:0] q1 [$];

    always #5 clk = ~clk;

    o_buft_ser_driver dut_a (
        .clk        (clk),
        .rst        (rst[0]),
        .data_in    (din[0]),
        .data_valid (valid[0]),
        .data_ready (a_ready),
        .ser_i      (a_ser_i),
        .ser_t      (a_ser_t),
        .busy       (a_busy),
        .word_done  (a_done)
    );

    o_buft_ser_driver #(
        .WIDTH        (8),
        .LSB_FIRST    (1),
        .GUARD_CYCLES (3)
    ) dut_b (
        .clk        (clk),
        .rst        (rst[1]),
        .data_in    (din[1]),
        .data_valid (valid[1]),
        .data_ready (b_ready),
        .ser_i      (b_ser_i),
        .ser_t      (b_ser_t),
        .busy       (b_busy),
        .word_done  (b_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic rdy(input int d);
        return (d == 0) ? a_ready : b_ready;
    endfunction

    function automatic logic bsy(input int d);
        return (d == 0) ? a_busy : b_busy;
    endfunction

    task automatic mon(input int d, input logic si, input logic st, input logic wd);
        logic [1:0] e;
        if (st) begin
            check($sformatf("sb_has_bit_%0d", d), 32'(qsize(d) != 0), 1);
            if (qsize(d) != 0) begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("ser_i_%0d", d), 32'(si), 32'(e[0]));
                check($sformatf("word_done_%0d", d), 32'(wd), 32'(e[1]));
            end
        end else begin
            check($sformatf("tristate_ser_i_%0d", d), 32'(si), 0);
            check($sformatf("tristate_done_%0d", d), 32'(wd), 0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_ser_i, a_ser_t, a_done);
        mon(1, b_ser_i, b_ser_t, b_done);
        if (a_done) wd_cnt[0]++;
        if (b_done) wd_cnt[1]++;
        if (a_ser_t) run_a++;
        else if (run_a != 0) begin
            last_run_a = run_a;
            run_a      = 0;
        end
    end

    // Called at a falling edge; returns at the falling edge after the transfer edge.
    task automatic put(input int d, input logic [7:0] w);
        int         k;
        int         idx;
        logic [1:0] e;
        din[d]      = w;
        valid[d]    = 1'b1;
        last_waited = 1'b0;
        k           = 0;
        while (!rdy(d) && k < 200) begin
            last_waited = 1'b1;
            @(negedge clk);
            k++;
        end
        check($sformatf("accept_%0d", d), 32'(rdy(d)), 1);
        for (int i = 0; i < 8; i++) begin
            idx = (d == 1) ? i : 7 - i;
            e   = {(i == 7), w[idx]};
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input int d);
        int k = 0;
        while ((bsy(d) || qsize(d) != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("drain_busy_%0d", d), 32'(bsy(d)), 0);
        check($sformatf("drain_queue_%0d", d), 32'(qsize(d)), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wd0;
        rst      = 2'b11;
        valid    = 2'b00;
        din[0]   = 8'h00;
        din[1]   = 8'h00;
        wd_cnt[0] = 0;
        wd_cnt[1] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ser_t_a", 32'(a_ser_t), 0);
        check("rst_busy_a",  32'(a_busy),  0);
        check("rst_ready_a", 32'(a_ready), 0);
        check("rst_ready_b", 32'(b_ready), 0);
        check("rst_ser_t_b", 32'(b_ser_t), 0);
        rst = 2'b00;
        @(negedge clk);
        check("post_rst_ready_a", 32'(a_ready), 1);
        check("post_rst_ready_b", 32'(b_ready), 1);

        // 0xA5 MSB first: latency, 8 driven cycles, guard, idle
        put(0, 8'hA5);
        valid[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("a5_ser_t", 32'(a_ser_t), 1);
            if (i == 7) check("a5_word_done", 32'(a_done), 1);
            @(negedge clk);
        end
        check("a5_guard_ser_t", 32'(a_ser_t), 0);
        check("a5_guard_busy",  32'(a_busy),  1);
        @(negedge clk);
        check("a5_idle_busy", 32'(a_busy), 0);

        // 0xFF then 0x00 back-to-back: 16-cycle unbroken burst
        wd0 = wd_cnt[0];
        put(0, 8'hFF);
        put(0, 8'h00);
        valid[0] = 1'b0;
        wait_idle(0);
        check("b2b_run_len", 32'(last_run_a), 16);
        check("b2b_word_done_cnt", 32'(wd_cnt[0] - wd0), 2);

        // Three words: third stalls on the full holding register
        wd0 = wd_cnt[0];
        put(0, 8'h81);
        put(0, 8'h42);
        put(0, 8'h24);
        check("three_ready_dropped", 32'(last_waited), 1);
        valid[0] = 1'b0;
        wait_idle(0);
        check("three_word_done_cnt", 32'(wd_cnt[0] - wd0), 3);
        check("three_run_len", 32'(last_run_a), 24);

        // Reset while bit 4 of 0x3C is on the pins
        wd0 = wd_cnt[0];
        put(0, 8'h3C);
        valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_bit4_ser_t", 32'(a_ser_t), 1);
        rst[0] = 1'b1;
        @(negedge clk);
        q0.delete();
        check("rst_mid_ser_t", 32'(a_ser_t), 0);
        check("rst_mid_busy",  32'(a_busy),  0);
        check("rst_mid_ready", 32'(a_ready), 0);
        rst[0] = 1'b0;
        @(negedge clk);
        check("rst_mid_ready_release", 32'(a_ready), 1);
        repeat (12) @(negedge clk);
        check("rst_mid_no_word_done", 32'(wd_cnt[0] - wd0), 0);
        put(0, 8'h96);
        valid[0] = 1'b0;
        wait_idle(0);

        // LSB first on dut_b
        put(1, 8'hA5);
        valid[1] = 1'b0;
        wait_idle(1);
        put(1, 8'h35);
        valid[1] = 1'b0;
        wait_idle(1);

        // Word accepted during a 3-cycle guard waits for IDLE
        put(1, 8'h5A);
        valid[1] = 1'b0;
        repeat (8) @(negedge clk);
        check("g3_guard1_ser_t", 32'(b_ser_t), 0);
        check("g3_guard1_busy",  32'(b_busy),  1);
        put(1, 8'hC3);
        valid[1] = 1'b0;
        check("g3_accept_no_wait", 32'(last_waited), 0);
        check("g3_guard2_ser_t", 32'(b_ser_t), 0);
        check("g3_guard2_busy",  32'(b_busy),  1);
        check("g3_hold_full",    32'(b_ready), 0);
        @(negedge clk);
        check("g3_guard3_ser_t", 32'(b_ser_t), 0);
        check("g3_guard3_busy",  32'(b_busy),  1);
        @(negedge clk);
        check("g3_idle_ser_t", 32'(b_ser_t), 0);
        check("g3_idle_busy",  32'(b_busy),  0);
        @(negedge clk);
        check("g3_first_bit_ser_t", 32'(b_ser_t), 1);
        wait_idle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/o_buft_ser_driver.md
O_BUFT_SER_DRIVER -- requirements
Module: o_buft_ser_driver

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width (legal 2..32).
REQ-002 Parameter LSB_FIRST, default 0; 0 = MSB shifted first, 1 = LSB first.
REQ-003 Parameter GUARD_CYCLES, default 1, idle tristate cycles after a burst (legal 1..15).
REQ-004 One clock; reset is synchronous and active-high; clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 data_in  input  WIDTH  parallel word to transmit.
REQ-007 data_valid  input  1  data_in valid.
REQ-008 data_ready  output  1  block can accept a word this cycle.
REQ-009 ser_i  output  1  serial data to O_BUFT_DS.I.
REQ-010 ser_t  output  1  drive enable to O_BUFT_DS.T; 1 = pads driven, 0 = tristate.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 word_done  output  1  one-cycle pulse coincident with last bit of each word on ser_i.

Function
REQ-013 Handshake: a word transfers on a rising edge where data_valid && data_ready; data_valid may not be withdrawn before transfer.
REQ-014 One-entry holding register plus WIDTH-bit shift register; data_ready = holding register empty, registered, and 0 during rst.
REQ-015 States: IDLE, SHIFT, GUARD.
REQ-016 IDLE: ser_t=0, ser_i=0, busy=0; on a load edge -> SHIFT.
REQ-017 Load edge: IDLE, or SHIFT on last bit; source = holding register if full, else data_in if transferring that edge (bypass); nothing loaded -> no state change except REQ-019.
REQ-018 Latency: word accepted at edge N in IDLE shows first bit on ser_i with ser_t=1 in cycle N+1; bits follow one per cycle, all WIDTH registered.
REQ-019 SHIFT: ser_t=1; bit counter 0..WIDTH-1; at count WIDTH-1 word_done=1; then load -> stay SHIFT with no gap, ser_t held 1; else -> GUARD.
REQ-020 GUARD: ser_t=0, ser_i=0 for exactly GUARD_CYCLES cycles, then IDLE; words may be accepted into holding register during GUARD but are not shifted until IDLE.
REQ-021 ser_i and ser_t change only on the same clock edge; no cycle with ser_t=1 and stale ser_i.
REQ-022 Holding full and shift register busy: data_ready=0; no word dropped or duplicated.
REQ-023 Counter wraps to 0 on every load; GUARD counter saturates then clears on exit.

Reset
REQ-024 On rst: state IDLE, ser_t=0, ser_i=0, busy=0, word_done=0, data_ready=0, holding register empty, counters 0.
REQ-025 data_ready rises in the first cycle after rst deasserts.
REQ-026 rst mid-word: word in flight and held word discarded; ser_t=0 from the next cycle; no GUARD period.

Structure
REQ-027 Package o_buft_ser_pkg holds the state enum (IDLE/SHIFT/GUARD) and default parameter constants.
REQ-028 Holding register and its valid/ready logic are one sub-module, o_buft_ser_hold; FSM, counters and shifter live in the top.

Verification
REQ-029 WIDTH=8, MSB-first, send 0xA5 from IDLE -> ser_i 1,0,1,0,0,1,0,1 in cycles N+1..N+8, ser_t=1 those 8 cycles, word_done in N+8, ser_t=0 in N+9, busy=0 from N+10.
REQ-030 LSB_FIRST=1, send 0xA5 -> ser_i 1,0,1,0,0,1,0,1 reversed order (1,0,1,0,0,1,0,1 read LSB-first = 1,0,1,0,0,1,0,1 checked bit-by-bit against data_in[0..7]).
REQ-031 Back-to-back 0xFF then 0x00 with data_valid held -> 16 consecutive ser_t=1 cycles, eight 1s then eight 0s, two word_done pulses, no gap.
REQ-032 Three words presented back-to-back -> data_ready drops while holding full; all three words serialized in order, none lost.
REQ-033 rst asserted at bit 4 of 0x3C -> ser_t=0 next cycle, remaining bits never appear, data_ready=1 one cycle after rst release.
REQ-034 GUARD_CYCLES=3, word accepted during GUARD -> ser_t low exactly 3 cycles, then first bit of new word one cycle after IDLE entry.
